dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the data-memory/IO block. It shares the single data-memory port between the CPU pipeline's load/store stage and the debug loader (program/data download and memory inspection). It issues at most one transaction at a time. It holds the address stable through the one-cycle read latency, so both BRAM reads and memory-mapped IO reads (addr[31]=1) return correct data. It routes each response back to the requester that issued it.

## Interface
- STARVE_LIMIT, 8: consecutive cycles a pending debug request may be refused before it takes priority; range 1..255.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU request; held, with cpu_we/addr/wdata stable, until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address; addr[31]=1 selects IO region.
- cpu_wdata  in  32  write data.
- cpu_gnt  out  1  one-cycle pulse: CPU transaction issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  32  read data, zero when cpu_rvalid=0.
- dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0]  in: debug-loader equivalents of the CPU inputs.
- dbg_gnt, dbg_rvalid, dbg_rdata[31:0]  out: debug-loader equivalents of the CPU outputs.
- mem_we  out  1  write strobe to data memory.
- mem_addr  out  32  address to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_rdata  in  32  data memory read data; valid the cycle after a read address is first presented, provided the address is held.

## Operation
- States:
  - IDLE: may issue.
  - RD_RESP: one cycle, read response pending.
- IDLE, no request:
  - no grant; mem_we=0.
  - mem_addr/mem_wdata hold their registered values.
- IDLE, request(s) present, winner selected:
  - CPU wins unless starve_cnt == STARVE_LIMIT and dbg_req=1; then debug wins.
  - Only one requester: that requester wins.
- Issue cycle:
  - Winner's gnt=1.
  - mem_addr/mem_wdata driven combinationally from the winner's inputs and captured into hold registers; the winner ID is captured.
  - Write: mem_we=1; state stays IDLE (a write takes 1 cycle, back-to-back writes allowed).
  - Read: mem_we=0; next state RD_RESP.
- RD_RESP:
  - mem_addr driven from the hold register; mem_we=0.
  - No grant to anyone, even if requests are pending.
  - The captured requester's rvalid=1 and its rdata=mem_rdata; the other requester's rdata=0.
  - Next state IDLE.
- Starvation counter starve_cnt (8 bit):
  - Increments, saturating at STARVE_LIMIT, each cycle dbg_req=1 and dbg_gnt=0.
  - Clears to 0 on dbg_gnt=1 or dbg_req=0.
- A requester may drop req before gnt (abort); no transaction results and no state change.
- Reset (rst_n=0 at any edge, including mid-read):
  - state=IDLE, starve_cnt=0, hold registers=0, captured ID=CPU.
  - All gnt/rvalid=0, all rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A pending read response is discarded; no rvalid after reset.

## Timing
- Write: request seen at cycle T with state IDLE → gnt and mem_we at T. Throughput is 1 write per cycle.
- Read: gnt at T, rvalid at T+1. Throughput is 1 read per 2 cycles.
- gnt is combinational from req and state. rvalid is combinational from state and captured ID.
- No output depends combinationally on mem_rdata except rdata.

## Configuration
- DMEM_ARB_STARVE_EN defined: the starvation counter and priority override above are present.
- DMEM_ARB_STARVE_EN undefined: strict CPU priority. The counter is not built, debug is granted only when cpu_req=0 in IDLE, and STARVE_LIMIT is ignored.

## Structure
- Package dmem_arb_pkg:
  - state enum {ARB_IDLE, ARB_RD_RESP}.
  - requester ID enum {REQ_CPU=0, REQ_DBG=1}.
  - DATA_W=32 and ADDR_W=32 constants.
- Sub-module dmem_arb_starve_ctr holds the saturating counter and the STARVE_LIMIT compare. It is instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- CPU write 0x0000_0010 ← 0xDEAD_BEEF, then CPU read of 0x0000_0010 → write gnt+mem_we in 1 cycle. The read issues the next cycle: gnt at T, cpu_rvalid at T+1 with cpu_rdata=0xDEAD_BEEF, mem_addr stable across T and T+1.
- IO read, cpu_addr=0x8000_0004 with opr2=0x5A → cpu_rdata=0x0000_005A at T+1; mem_addr still 0x8000_0004 in the RD_RESP cycle.
- Simultaneous cpu_req and dbg_req reads, same cycle → CPU granted first, debug granted 2 cycles later, and each rvalid goes only to its owner.
- STARVE_LIMIT=8 with cpu_req held high issuing writes and dbg_req high → dbg_gnt on the 9th cycle of dbg_req, then CPU resumes. With the macro undefined, dbg_gnt never occurs while cpu_req=1.
- rst_n low in the RD_RESP cycle → no rvalid on either side, all outputs 0 the next cycle, state IDLE.
- Debug write 0x8000_0008 ← 0x0000_1234 → the IO result register (display value) reads 0x1234 one cycle after dbg_gnt.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared widths, state and requester encodings for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STARVE_W = 8;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_RD_RESP = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  // Out-of-range limits are pinned into 1..255 so the counter compare stays reachable.
  function automatic logic [STARVE_W-1:0] starve_limit_clamp(input int unsigned limit);
    if (limit < 1) begin
      return STARVE_W'(1);
    end
    if (limit > 255) begin
      return STARVE_W'(255);
    end
    return STARVE_W'(limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signals shared by the arbiter and its clients
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// rtl/dmem_arb_starve_ctr.sv - saturating count of consecutive refused debug cycles
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic starve_hit
);

  localparam logic [STARVE_W-1:0] LIMIT = starve_limit_clamp(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req || dbg_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_hit = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter for the single data-memory port, one transaction at a time
// DMEM_ARB_STARVE_EN adds a debug anti-starvation override; otherwise the CPU has strict priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE    = ARB_IDLE;
  localparam logic [0:0] ST_RD_RESP = ARB_RD_RESP;

  logic [0:0]        state_q, state_d;
  req_id_e           id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              idle, rd_resp;
  logic              cpu_win, dbg_win, issue;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              dbg_override;

`ifdef DMEM_ARB_STARVE_EN
  logic starve_hit;

  dmem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .dbg_req    (bus.dbg_req),
    .dbg_gnt    (dbg_win),
    .starve_hit (starve_hit)
  );

  assign dbg_override = starve_hit & bus.dbg_req;
`else
  logic unused_starve_limit;

  assign unused_starve_limit = ^starve_limit_clamp(STARVE_LIMIT);
  assign dbg_override        = 1'b0;
`endif

  // Reset gates every output so nothing leaks from a transaction cut short by rst_n.
  always_comb begin
    idle      = rst_n && (state_q == ST_IDLE);
    rd_resp   = rst_n && (state_q == ST_RD_RESP);
    cpu_win   = idle && bus.cpu_req && !dbg_override;
    dbg_win   = idle && bus.dbg_req && (!bus.cpu_req || dbg_override);
    issue     = cpu_win || dbg_win;
    win_we    = dbg_win ? bus.dbg_we    : bus.cpu_we;
    win_addr  = dbg_win ? bus.dbg_addr  : bus.cpu_addr;
    win_wdata = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
  end

  always_comb begin
    state_d = ST_IDLE;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (issue) begin
      state_d = win_we ? ST_IDLE : ST_RD_RESP;
      id_d    = dbg_win ? REQ_DBG : REQ_CPU;
      addr_d  = win_addr;
      wdata_d = win_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= REQ_CPU;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    bus.cpu_gnt    = cpu_win;
    bus.dbg_gnt    = dbg_win;
    bus.cpu_rvalid = rd_resp && (id_q == REQ_CPU);
    bus.dbg_rvalid = rd_resp && (id_q == REQ_DBG);
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;
    bus.mem_we     = issue && win_we;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    // The hold registers keep the read address steady through the response cycle.
    if (issue) begin
      bus.mem_addr  = win_addr;
      bus.mem_wdata = win_wdata;
    end else if (rst_n) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized scoreboard bench for dmem_arbiter with a memory/IO slave model
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned STARVE_LIMIT = 8;
  localparam logic [31:0] OPR2_ADDR = 32'h8000_0004;
  localparam logic [31:0] DISP_ADDR = 32'h8000_0008;
  localparam logic [31:0] OPR2_VAL  = 32'h0000_005A;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
    int          max_wait;
  } op_t;

  typedef struct {
    bit          owner;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory/IO slave: one-cycle registered read of whatever address is presented.
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] slv_rdata_q = '0;
  logic [31:0] display_q = '0;

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    if (a == OPR2_ADDR) return OPR2_VAL;
    if (a == DISP_ADDR) return display_q;
    if (slv_mem.exists(a)) return slv_mem[a];
    return '0;
  endfunction

  always @(posedge clk) begin
    slv_rdata_q <= slv_read(bus.mem_addr);
    if (bus.mem_we) begin
      if (bus.mem_addr == DISP_ADDR) display_q <= bus.mem_wdata;
      else if (bus.mem_addr != OPR2_ADDR) slv_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = slv_rdata_q;

  // Requester drivers: index 0 = CPU, 1 = debug.
  op_t cpu_ops[$];
  op_t dbg_ops[$];
  bit          s_req[2];
  bit          s_we[2];
  logic [31:0] s_addr[2];
  logic [31:0] s_wd[2];
  int          s_gap[2];
  int          s_wait[2];
  int          s_max[2];
  bit          s_seen[2];

  assign bus.cpu_req   = s_req[0];
  assign bus.cpu_we    = s_we[0];
  assign bus.cpu_addr  = s_addr[0];
  assign bus.cpu_wdata = s_wd[0];
  assign bus.dbg_req   = s_req[1];
  assign bus.dbg_we    = s_we[1];
  assign bus.dbg_addr  = s_addr[1];
  assign bus.dbg_wdata = s_wd[1];

  task automatic push_op(input bit side, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gap, input int max_wait);
    op_t op;
    op.we = we; op.addr = addr; op.wdata = wdata; op.gap = gap; op.max_wait = max_wait;
    if (side) dbg_ops.push_back(op);
    else cpu_ops.push_back(op);
  endtask

  always @(posedge clk) begin
    op_t op;
    bit have, aborted;
    #1;
    for (int s = 0; s < 2; s++) begin
      aborted = 1'b0;
      if (s_req[s]) begin
        if (s_seen[s]) s_req[s] = 1'b0;
        else begin
          s_wait[s]++;
          if (s_max[s] != 0 && s_wait[s] >= s_max[s]) begin
            s_req[s] = 1'b0;
            aborted = 1'b1;
          end
        end
      end
      if (!s_req[s] && !aborted) begin
        if (s_gap[s] > 0) s_gap[s]--;
        else begin
          have = 1'b0;
          if (s == 0 && cpu_ops.size() > 0) begin op = cpu_ops.pop_front(); have = 1'b1; end
          if (s == 1 && dbg_ops.size() > 0) begin op = dbg_ops.pop_front(); have = 1'b1; end
          if (have) begin
            s_req[s] = 1'b1; s_we[s] = op.we; s_addr[s] = op.addr; s_wd[s] = op.wdata;
            s_wait[s] = 0; s_max[s] = op.max_wait; s_gap[s] = op.gap;
          end
        end
      end
    end
  end

  // Reference model: transaction-level rules plus a flat memory image.
  logic [31:0] ref_mem [logic [31:0]];
  exp_t        exp_q[$];
  bit          m_rd_busy = 1'b0;
  bit          m_rd_owner = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_hold_addr = '0;
  logic [31:0] m_hold_wd = '0;
  int          cyc = 0;
  int          last_cpu_gnt_cyc = 0;
  int          last_dbg_gnt_cyc = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a == OPR2_ADDR) return OPR2_VAL;
    if (ref_mem.exists(a)) return ref_mem[a];
    return '0;
  endfunction

  always @(negedge clk) begin
    bit gc, gd, we;
    logic [31:0] a, wd;
    exp_t e;
    cyc++;
    s_seen[0] = bus.cpu_gnt;
    s_seen[1] = bus.dbg_gnt;
    if (!rst_n) begin
      check("rst_cpu_gnt", bus.cpu_gnt, 0);
      check("rst_dbg_gnt", bus.dbg_gnt, 0);
      check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
      check("rst_dbg_rvalid", bus.dbg_rvalid, 0);
      check("rst_cpu_rdata", bus.cpu_rdata, 0);
      check("rst_dbg_rdata", bus.dbg_rdata, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      m_rd_busy = 1'b0; m_wait = 0; m_hold_addr = '0; m_hold_wd = '0;
      exp_q.delete();
    end else begin
      check("cpu_rvalid", bus.cpu_rvalid, m_rd_busy && !m_rd_owner);
      check("dbg_rvalid", bus.dbg_rvalid, m_rd_busy && m_rd_owner);
      if (!(m_rd_busy && !m_rd_owner)) check("cpu_rdata_idle", bus.cpu_rdata, 0);
      if (!(m_rd_busy && m_rd_owner)) check("dbg_rdata_idle", bus.dbg_rdata, 0);
      gc = 1'b0; gd = 1'b0;
      if (!m_rd_busy) begin
        if (bus.cpu_req && bus.dbg_req) begin
`ifdef DMEM_ARB_STARVE_EN
          if (m_wait >= int'(STARVE_LIMIT)) gd = 1'b1;
          else gc = 1'b1;
`else
          gc = 1'b1;
`endif
        end else begin
          gc = bus.cpu_req;
          gd = bus.dbg_req;
        end
      end
      check("cpu_gnt", bus.cpu_gnt, gc);
      check("dbg_gnt", bus.dbg_gnt, gd);
      if (gc || gd) begin
        we = gd ? bus.dbg_we : bus.cpu_we;
        a  = gd ? bus.dbg_addr : bus.cpu_addr;
        wd = gd ? bus.dbg_wdata : bus.cpu_wdata;
        check("issue_mem_we", bus.mem_we, we);
        check("issue_mem_addr", bus.mem_addr, a);
        check("issue_mem_wdata", bus.mem_wdata, wd);
        m_hold_addr = a; m_hold_wd = wd;
        if (we) begin
          if (a != OPR2_ADDR) ref_mem[a] = wd;
          m_rd_busy = 1'b0;
        end else begin
          e.owner = gd; e.addr = a; e.data = ref_read(a);
          exp_q.push_back(e);
          m_rd_busy = 1'b1; m_rd_owner = gd;
        end
        if (gc) last_cpu_gnt_cyc = cyc;
        if (gd) last_dbg_gnt_cyc = cyc;
      end else begin
        check("quiet_mem_we", bus.mem_we, 0);
        check("quiet_mem_addr", bus.mem_addr, m_hold_addr);
        check("quiet_mem_wdata", bus.mem_wdata, m_hold_wd);
        m_rd_busy = 1'b0;
      end
      if (bus.dbg_req && !gd) m_wait++;
      else m_wait = 0;
    end
  end

  // Response monitor: pops one expectation for every rvalid the DUT presents.
  exp_t        mon_e;
  logic [31:0] last_cpu_rdata = '0;
  logic [31:0] last_dbg_rdata = '0;

  always @(negedge clk) begin
    if (bus.cpu_rvalid || bus.dbg_rvalid) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("rvalid_both", bus.cpu_rvalid && bus.dbg_rvalid, 0);
        check("rvalid_owner", bus.dbg_rvalid, mon_e.owner);
        check("rd_hold_addr", bus.mem_addr, mon_e.addr);
        check("rdata", mon_e.owner ? bus.dbg_rdata : bus.cpu_rdata, mon_e.data);
        if (mon_e.owner) last_dbg_rdata = bus.dbg_rdata;
        else last_cpu_rdata = bus.cpu_rdata;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((cpu_ops.size() > 0 || dbg_ops.size() > 0 || s_req[0] || s_req[1] ||
            s_gap[0] > 0 || s_gap[1] > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_gnt(input bit side, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(side ? bus.dbg_gnt : bus.cpu_gnt) && n < 100);
    if (n >= 100) check(name, 0, 1);
  endtask

  logic [31:0] addr_pool[6];

  initial begin
    int n;
    bit cpu_at_gnt;
    slv_mem[32'h0] = '0;
    ref_mem[32'h0] = '0;
    addr_pool[0] = 32'h10; addr_pool[1] = 32'h14; addr_pool[2] = 32'h18;
    addr_pool[3] = 32'h1C; addr_pool[4] = DISP_ADDR; addr_pool[5] = OPR2_ADDR;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_mem_addr", bus.mem_addr, 0);

    push_op(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0);
    push_op(0, 0, 32'h10, 32'h0, 0, 0);
    wait_idle();
    check("cpu_read_back", last_cpu_rdata, 32'hDEAD_BEEF);

    push_op(0, 0, OPR2_ADDR, 32'h0, 0, 0);
    wait_idle();
    check("io_read_opr2", last_cpu_rdata, 32'h0000_005A);

    push_op(0, 0, 32'h14, 32'h0, 0, 0);
    push_op(1, 0, 32'h10, 32'h0, 0, 0);
    wait_idle();
    check("dbg_gnt_two_after_cpu", last_dbg_gnt_cyc - last_cpu_gnt_cyc, 2);
    check("dbg_read_back", last_dbg_rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 20; i++) push_op(0, 1, 32'h20 + 32'(4 * i), $urandom, 0, 0);
    push_op(1, 1, 32'h18, 32'hCAFE_0018, 0, 0);
    n = 0;
    cpu_at_gnt = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.dbg_req) n++;
      if (bus.dbg_gnt) begin
        cpu_at_gnt = bus.cpu_req;
        break;
      end
    end
`ifdef DMEM_ARB_STARVE_EN
    check("starve_gnt_cycle", n, STARVE_LIMIT + 1);
    check("starve_cpu_still_req", cpu_at_gnt, 1);
`else
    check("strict_no_dbg_while_cpu", cpu_at_gnt, 0);
    check("strict_dbg_wait", n, 21);
`endif
    wait_idle();

    push_op(0, 0, 32'h10, 32'h0, 0, 0);
    wait_gnt(0, "reset_read_gnt_timeout");
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("after_rst_dbg_rvalid", bus.dbg_rvalid, 0);
    check("after_rst_mem_addr", bus.mem_addr, 0);
    wait_idle();

    push_op(1, 1, DISP_ADDR, 32'h0000_1234, 0, 0);
    wait_gnt(1, "display_gnt_timeout");
    @(negedge clk);
    check("display_value", display_q, 32'h0000_1234);
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      for (int s = 0; s < 2; s++) begin
        logic [31:0] a;
        bit w;
        a = addr_pool[$urandom_range(0, 5)];
        w = $urandom_range(0, 1) == 1 && a != OPR2_ADDR;
        push_op(s[0], w, a, $urandom, $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
